// File: rtl/nco_tune_ctrl.sv
// NCO tuning controller: accepts single-tune and scan commands, drives the phase-increment
// word to the NCO and blanks the mixer/CIC path with a mute strobe around every retune.
module nco_tune_ctrl #(
    parameter int PHASE_W       = 32,
    parameter int COUNT_W       = 16,
    parameter int DWELL_W       = 24,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_mode,
    input  logic [PHASE_W-1:0] cmd_freq,
    input  logic [PHASE_W-1:0] cmd_step,
    input  logic [COUNT_W-1:0] cmd_count,
    input  logic [DWELL_W-1:0] cmd_dwell,
    input  logic               abort,
    output logic [PHASE_W-1:0] phase_inc,
    output logic               phase_load,
    output logic               mute,
    output logic               busy,
    output logic               scan_done,
    output logic [COUNT_W-1:0] scan_index,
    output logic [2:0]         dbg_state
);

    // Command handshake: a command transfers on a rising clk edge where cmd_valid and
    // cmd_ready are both high; cmd_ready is high only in IDLE with abort low, and the
    // source must hold cmd_valid and all cmd_* fields stable until that edge.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_DWELL  = 3'd3,
        S_STEP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1) + 1;
    localparam int CNT_W = (DWELL_W > SET_W) ? DWELL_W : SET_W;
    localparam logic [CNT_W-1:0] SETTLE_LAST =
        CNT_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);

    state_t               state_q, state_d;
    logic                 mode_q, mode_d;
    logic [PHASE_W-1:0]   step_q, step_d;
    logic [COUNT_W-1:0]   last_idx_q, last_idx_d;
    logic [DWELL_W-1:0]   dwell_m1_q, dwell_m1_d;
    logic [PHASE_W-1:0]   cur_freq_q, cur_freq_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PHASE_W-1:0]   phase_inc_q, phase_inc_d;
    logic                 phase_load_q, phase_load_d;
    logic                 mute_q, mute_d;
    logic                 busy_q, busy_d;
    logic                 scan_done_q, scan_done_d;
    logic [COUNT_W-1:0]   scan_index_q, scan_index_d;
    logic                 accept;
    logic [PHASE_W-1:0]   next_freq;

    assign cmd_ready = (state_q == S_IDLE) && !abort;
    assign accept    = cmd_valid && cmd_ready;
    assign next_freq = cur_freq_q + step_q;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        step_d       = step_q;
        last_idx_d   = last_idx_q;
        dwell_m1_d   = dwell_m1_q;
        cur_freq_d   = cur_freq_q;
        cnt_d        = cnt_q;
        phase_inc_d  = phase_inc_q;
        scan_index_d = scan_index_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mode_d       = cmd_mode;
                    step_d       = cmd_step;
                    last_idx_d   = (cmd_count == '0) ? '0 : (cmd_count - COUNT_W'(1));
                    dwell_m1_d   = (cmd_dwell == '0) ? '0 : (cmd_dwell - DWELL_W'(1));
                    cur_freq_d   = cmd_freq;
                    phase_inc_d  = cmd_freq;
                    scan_index_d = '0;
                    state_d      = S_LOAD;
                end
            end

            S_LOAD: begin
                // The load cycle already counts as the first muted cycle.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (SETTLE_CYCLES > 0) begin
                    cnt_d   = SETTLE_LAST;
                    state_d = S_SETTLE;
                end else if (!mode_q) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = CNT_W'(dwell_m1_q);
                    state_d = S_DWELL;
                end
            end

            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!mode_q) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = CNT_W'(dwell_m1_q);
                    state_d = S_DWELL;
                end
            end

            S_DWELL: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (scan_index_q == last_idx_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_STEP;
                end
            end

            S_STEP: begin
                // Advance here so the new word is presented in the LOAD cycle itself.
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    cur_freq_d   = next_freq;
                    phase_inc_d  = next_freq;
                    scan_index_d = scan_index_q + COUNT_W'(1);
                    state_d      = S_LOAD;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        phase_load_d = (state_d == S_LOAD);
        mute_d       = (state_d == S_LOAD) || (state_d == S_SETTLE);
        busy_d       = (state_d != S_IDLE);
        scan_done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mode_q       <= 1'b0;
            step_q       <= '0;
            last_idx_q   <= '0;
            dwell_m1_q   <= '0;
            cur_freq_q   <= '0;
            cnt_q        <= '0;
            phase_inc_q  <= '0;
            phase_load_q <= 1'b0;
            mute_q       <= 1'b0;
            busy_q       <= 1'b0;
            scan_done_q  <= 1'b0;
            scan_index_q <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            step_q       <= step_d;
            last_idx_q   <= last_idx_d;
            dwell_m1_q   <= dwell_m1_d;
            cur_freq_q   <= cur_freq_d;
            cnt_q        <= cnt_d;
            phase_inc_q  <= phase_inc_d;
            phase_load_q <= phase_load_d;
            mute_q       <= mute_d;
            busy_q       <= busy_d;
            scan_done_q  <= scan_done_d;
            scan_index_q <= scan_index_d;
        end
    end

    assign phase_inc  = phase_inc_q;
    assign phase_load = phase_load_q;
    assign mute       = mute_q;
    assign busy       = busy_q;
    assign scan_done  = scan_done_q;
    assign scan_index = scan_index_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_nco_tune_ctrl.sv
// Bench for nco_tune_ctrl: directed vector table, hand-written reset/abort sequences and
// randomized commands, all compared cycle by cycle against a closed-form timeline model.
module tb_nco_tune_ctrl;

    localparam int S = 8;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_mode;
    logic [31:0] cmd_freq;
    logic [31:0] cmd_step;
    logic [15:0] cmd_count;
    logic [23:0] cmd_dwell;
    logic        abort;
    logic [31:0] phase_inc;
    logic        phase_load;
    logic        mute;
    logic        busy;
    logic        scan_done;
    logic [15:0] scan_index;
    logic [2:0]  dbg_state;

    nco_tune_ctrl #(
        .PHASE_W(32), .COUNT_W(16), .DWELL_W(24), .SETTLE_CYCLES(S)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_freq(cmd_freq), .cmd_step(cmd_step),
        .cmd_count(cmd_count), .cmd_dwell(cmd_dwell), .abort(abort),
        .phase_inc(phase_inc), .phase_load(phase_load), .mute(mute), .busy(busy),
        .scan_done(scan_done), .scan_index(scan_index), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        mode;
        logic [31:0] freq;
        logic [31:0] step;
        logic [15:0] count;
        logic [23:0] dwell;
        int          abort_k;
        logic [31:0] exp_phase;
        logic [15:0] exp_index;
        int          exp_loads;
        int          exp_dones;
    } vec_t;

    typedef struct {
        logic        busy;
        logic        mute;
        logic        load;
        logic        done;
        logic [31:0] phase;
        logic [15:0] idx;
    } exp_t;

    // Timeline model: k counts cycles from the first load cycle (k=0).
    logic        m_mode;
    logic [31:0] m_freq;
    logic [31:0] m_step;
    int          m_n, m_d, m_p, m_busy_last, m_ka;

    function automatic exp_t ideal_at(input int k);
        exp_t e;
        int   c;
        c = 0;
        if (m_mode) begin
            c = k / m_p;
            if (c > m_n - 1) c = m_n - 1;
        end
        e.phase = m_freq + 32'(c) * m_step;
        e.idx   = 16'(c);
        e.busy  = (k <= m_busy_last);
        e.load  = (k == c * m_p);
        e.mute  = e.busy && ((k - c * m_p) <= S);
        e.done  = m_mode && (k == m_busy_last);
        return e;
    endfunction

    function automatic exp_t model_at(input int k);
        exp_t e;
        if (m_ka >= 0 && k > m_ka) begin
            e      = ideal_at(m_ka);
            e.busy = 1'b0;
            e.mute = 1'b0;
            e.load = 1'b0;
            e.done = 1'b0;
        end else begin
            e = ideal_at(k);
        end
        return e;
    endfunction

    task automatic run_cmd(input vec_t v, input string tag, input bit summary);
        exp_t e;
        int   loads, dones, last;
        m_mode      = v.mode;
        m_freq      = v.freq;
        m_step      = v.step;
        m_n         = (v.count == 0) ? 1 : int'(v.count);
        m_d         = (v.dwell == 0) ? 1 : int'(v.dwell);
        m_p         = S + m_d + 2;
        m_busy_last = v.mode ? ((m_n - 1) * m_p + S + m_d + 1) : S;
        m_ka        = (v.abort_k >= 0 && v.abort_k <= m_busy_last) ? v.abort_k : -1;
        last        = ((m_ka >= 0) ? m_ka : m_busy_last) + 3;

        cmd_mode  = v.mode;
        cmd_freq  = v.freq;
        cmd_step  = v.step;
        cmd_count = v.count;
        cmd_dwell = v.dwell;
        abort     = 1'b0;
        cmd_valid = 1'b1;
        #1;
        chk($sformatf("%s ready_pre", tag), 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        loads = 0;
        dones = 0;
        for (int k = 0; k <= last; k++) begin
            e = model_at(k);
            chk($sformatf("%s k=%0d phase_load", tag, k), 32'(phase_load), 32'(e.load));
            chk($sformatf("%s k=%0d mute", tag, k), 32'(mute), 32'(e.mute));
            chk($sformatf("%s k=%0d busy", tag, k), 32'(busy), 32'(e.busy));
            chk($sformatf("%s k=%0d scan_done", tag, k), 32'(scan_done), 32'(e.done));
            chk($sformatf("%s k=%0d phase_inc", tag, k), phase_inc, e.phase);
            chk($sformatf("%s k=%0d scan_index", tag, k), 32'(scan_index), 32'(e.idx));
            loads += int'(phase_load);
            dones += int'(scan_done);
            abort = (k == v.abort_k);
            #1;
            chk($sformatf("%s k=%0d cmd_ready", tag, k), 32'(cmd_ready),
                32'(!e.busy && !abort));
            @(posedge clk);
            #1;
        end
        abort = 1'b0;
        if (summary) begin
            chk($sformatf("%s final phase_inc", tag), phase_inc, v.exp_phase);
            chk($sformatf("%s final scan_index", tag), 32'(scan_index), 32'(v.exp_index));
            chk($sformatf("%s load count", tag), 32'(loads), 32'(v.exp_loads));
            chk($sformatf("%s done count", tag), 32'(dones), 32'(v.exp_dones));
        end
    endtask

    vec_t vecs[7];
    vec_t rv;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // mode freq step count dwell abort_k | phase index loads dones
        vecs[0] = '{1'b0, 32'h0A3D70A4, 32'h0, 16'd0, 24'd0, -1, 32'h0A3D70A4, 16'd0, 1, 0};
        vecs[1] = '{1'b1, 32'h100, 32'h10, 16'd3, 24'd4, -1, 32'h120, 16'd2, 3, 1};
        vecs[2] = '{1'b1, 32'hFFFFFFF0, 32'h20, 16'd2, 24'd3, -1, 32'h10, 16'd1, 2, 1};
        vecs[3] = '{1'b1, 32'h100, 32'hFFFFFFF0, 16'd2, 24'd2, -1, 32'hF0, 16'd1, 2, 1};
        vecs[4] = '{1'b1, 32'h5555, 32'h1, 16'd0, 24'd0, -1, 32'h5555, 16'd0, 1, 1};
        // Second DWELL of channel 1 spans k=25..30 with dwell 6.
        vecs[5] = '{1'b1, 32'h1000, 32'h100, 16'd5, 24'd6, 27, 32'h1100, 16'd1, 2, 0};
        // Abort raised during the LOAD cycle: the load still shows.
        vecs[6] = '{1'b1, 32'h2000, 32'h1, 16'd3, 24'd2, 0, 32'h2000, 16'd0, 1, 0};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_mode  = 1'b0;
        cmd_freq  = '0;
        cmd_step  = '0;
        cmd_count = '0;
        cmd_dwell = '0;
        abort     = 1'b0;
        #12;
        chk("reset phase_inc", phase_inc, 32'h0);
        chk("reset phase_load", 32'(phase_load), 32'd0);
        chk("reset mute", 32'(mute), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset scan_done", 32'(scan_done), 32'd0);
        chk("reset scan_index", 32'(scan_index), 32'd0);
        chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) run_cmd(vecs[i], $sformatf("vec%0d", i), 1'b1);

        // abort held together with cmd_valid in IDLE must not start anything.
        cmd_mode  = 1'b0;
        cmd_freq  = 32'hCAFE0000;
        cmd_valid = 1'b1;
        abort     = 1'b1;
        #1;
        chk("idle abort cmd_ready", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("idle abort busy c%0d", i), 32'(busy), 32'd0);
            chk($sformatf("idle abort phase_load c%0d", i), 32'(phase_load), 32'd0);
            chk($sformatf("idle abort phase_inc c%0d", i), phase_inc, 32'h2000);
        end
        cmd_valid = 1'b0;
        abort     = 1'b0;

        // Reset asserted mid-SETTLE takes effect without a clock edge.
        cmd_mode  = 1'b1;
        cmd_freq  = 32'hDEAD0000;
        cmd_step  = 32'h1;
        cmd_count = 16'd4;
        cmd_dwell = 24'd3;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre-reset mute", 32'(mute), 32'd1);
        chk("pre-reset phase_inc", phase_inc, 32'hDEAD0000);
        rst_n = 1'b0;
        #1;
        chk("async reset phase_inc", phase_inc, 32'h0);
        chk("async reset mute", 32'(mute), 32'd0);
        chk("async reset busy", 32'(busy), 32'd0);
        chk("async reset phase_load", 32'(phase_load), 32'd0);
        chk("async reset scan_index", 32'(scan_index), 32'd0);
        chk("async reset cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("held reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post reset busy", 32'(busy), 32'd0);
        rv = '{1'b1, 32'h1234, 32'h10, 16'd2, 24'd1, -1, 32'h1244, 16'd1, 2, 1};
        run_cmd(rv, "post_reset", 1'b1);

        for (int i = 0; i < 20; i++) begin
            rv.mode    = 1'($urandom_range(0, 1));
            rv.freq    = $urandom;
            rv.step    = $urandom;
            rv.count   = 16'($urandom_range(0, 4));
            rv.dwell   = 24'($urandom_range(0, 5));
            rv.abort_k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
            run_cmd(rv, $sformatf("rnd%0d", i), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
